// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq -- multi-cycle radix-2 restoring divider for DIV / DIVU.
//
// A request is accepted from IDLE. The divider then produces one quotient bit
// per clock and returns {remainder, quotient} with the signs corrected. A zero
// divisor is detected at accept time and gives a zero result after one extra
// state. The EX stage holds start_i until it sees ready_o.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   signed_div_i  1 = signed divide (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held high until ready_o is seen
//   annul_i       abort the current operation (flush / exception)
//   result_o      {remainder, quotient}, valid only while ready_o = 1
//   ready_o       result valid, high only in state END
// -----------------------------------------------------------------------------
module div_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

  state_t              state, state_next;
  logic                is_signed, sign1, sign2;
  logic [DATA_W-1:0]   dvs;        // divisor magnitude
  logic [DATA_W-1:0]   rem;        // partial remainder
  logic [DATA_W-1:0]   quo;        // dividend bits shifting out, quotient bits shifting in
  logic [CNT_W-1:0]    cnt;

  logic [2*DATA_W-1:0] result_next;
  logic                ready_next;

  logic [DATA_W:0]     trial;
  logic [DATA_W-1:0]   rem_step, quo_step;
  logic [DATA_W-1:0]   q_fix, r_fix;
  logic [DATA_W-1:0]   mag1, mag2;
  logic                accept, last_step;

  // Magnitudes of the incoming operands. The most-negative value negates to
  // itself and is then read as an unsigned magnitude, which is what we want.
  assign mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  assign accept    = (state == IDLE) && start_i && !annul_i;
  assign last_step = (cnt == CNT_W'(DATA_W - 1));

  // One restoring step. The trial is one bit wider than the remainder so the
  // shifted-in value never overflows; its top bit is the borrow.
  always_comb begin
    trial    = {rem, quo[DATA_W-1]} - {1'b0, dvs};
    rem_step = trial[DATA_W] ? {rem[DATA_W-2:0], quo[DATA_W-1]} : trial[DATA_W-1:0];
    quo_step = {quo[DATA_W-2:0], ~trial[DATA_W]};
    q_fix    = (is_signed && (sign1 ^ sign2)) ? -quo_step : quo_step;
    r_fix    = (is_signed && sign1)           ? -rem_step : rem_step;
  end

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    result_next = result_o;
    ready_next  = 1'b0;
    unique case (state)
      IDLE: begin
        result_next = '0;
        if (accept) state_next = (opdata2_i == '0) ? BYZERO : ON;
      end
      BYZERO: begin
        result_next = '0;
        if (annul_i) begin
          state_next = IDLE;
        end else begin
          state_next = END;
          ready_next = 1'b1;
        end
      end
      ON: begin
        // annul wins over completion of the last step
        if (annul_i) begin
          state_next  = IDLE;
          result_next = '0;
        end else if (last_step) begin
          state_next  = END;
          result_next = {r_fix, q_fix};
          ready_next  = 1'b1;
        end
      end
      END: begin
        if (!start_i || annul_i) begin
          state_next  = IDLE;
          result_next = '0;
        end else begin
          ready_next  = 1'b1;
        end
      end
      default: begin
        state_next  = IDLE;
        result_next = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_next;
      result_o <= result_next;
      ready_o  <= ready_next;
    end
  end

  // Datapath: operands latched on accept, so later changes on the inputs are
  // ignored while the divide runs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_signed <= 1'b0;
      sign1     <= 1'b0;
      sign2     <= 1'b0;
      dvs       <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
    end else if (accept && (opdata2_i != '0)) begin
      is_signed <= signed_div_i;
      sign1     <= signed_div_i && opdata1_i[DATA_W-1];
      sign2     <= signed_div_i && opdata2_i[DATA_W-1];
      dvs       <= mag2;
      rem       <= '0;
      quo       <= mag1;
      cnt       <= '0;
    end else if ((state == ON) && !annul_i) begin
      rem       <= rem_step;
      quo       <= quo_step;
      cnt       <= cnt + 1'b1;
    end
  end

endmodule
